// File: rtl/fft_reorder_pkg.sv
// Shared constants, types and the bin bit-reversal helper for the FFT output
// reorder buffer.
package fft_reorder_pkg;

    localparam int unsigned WIDTH  = 13;
    localparam int unsigned N      = 512;
    localparam int unsigned LANES  = 16;
    localparam int unsigned BEATS  = N / LANES;
    localparam int unsigned LOG2N  = 9;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned BEAT_W = 5;

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef sample_t frame_t [N];
    typedef sample_t beat_t  [LANES];

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev9(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Frame input and beat output stream between the FFT core, the reorder
// buffer (slave) and the downstream consumer (master).
interface fft_out_reorder_if;
    import fft_reorder_pkg::*;

    frame_t              din_re;
    frame_t              din_im;
    logic                din_en;
    beat_t               dout_re;
    beat_t               dout_im;
    logic                dout_valid;
    logic                dout_ready;
    logic [BEAT_W-1:0]   dout_beat;
    logic                dout_last;
    logic                overflow;

    modport slave (
        input  din_re, din_im, din_en, dout_ready,
        output dout_re, dout_im, dout_valid, dout_beat, dout_last, overflow
    );

    modport master (
        output din_re, din_im, din_en, dout_ready,
        input  dout_re, dout_im, dout_valid, dout_beat, dout_last, overflow
    );

endinterface

// File: rtl/fft_reorder_bank.sv
// One frame bank: captures a whole bit-reversed frame and reads back one beat
// of 16 consecutive natural-order bins.
module fft_reorder_bank
    import fft_reorder_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  frame_t            i_re,
    input  frame_t            i_im,
    input  logic [BEAT_W-1:0] i_beat,
    output beat_t             o_re_c,
    output beat_t             o_im_c
);

    frame_t r_re;
    frame_t r_im;

    // Contents need no reset: validity is tracked by the owner's full flag.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_re <= i_re;
            r_im <= i_im;
        end
    end

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            o_re_c[l] = r_re[bitrev9({i_beat, LANE_W'(l)})];
            o_im_c[l] = r_im[bitrev9({i_beat, LANE_W'(l)})];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer after the 512-point FFT: captures bit-reversed
// frames and streams them as 32 natural-order beats of 16 bins.
module fft_out_reorder
    import fft_reorder_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    fft_out_reorder_if.slave   bus
);

    state_t            r_state;
    logic [1:0]        r_full;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    beat_t             r_dout_re;
    beat_t             r_dout_im;
    logic              r_valid;
    logic              r_last;
    logic [BEAT_W-1:0] r_beat;
    logic              r_overflow;

    beat_t             w_re0, w_im0, w_re1, w_im1;
    beat_t             w_ld_re, w_ld_im;
    logic [1:0]        w_we;
    logic [1:0]        w_full_rel;
    logic [1:0]        w_full_nxt;
    logic              w_hs, w_release, w_accept, w_drop;
    logic              w_load, w_ld_bank;
    logic [BEAT_W-1:0] w_ld_beat;

    fft_reorder_bank u_bank0 (
        .clk    (clk),
        .i_we   (w_we[0]),
        .i_re   (bus.din_re),
        .i_im   (bus.din_im),
        .i_beat (w_ld_beat),
        .o_re_c (w_re0),
        .o_im_c (w_im0)
    );

    fft_reorder_bank u_bank1 (
        .clk    (clk),
        .i_we   (w_we[1]),
        .i_re   (bus.din_re),
        .i_im   (bus.din_im),
        .i_beat (w_ld_beat),
        .o_re_c (w_re1),
        .o_im_c (w_im1)
    );

    // A bank released on this edge is already free for an incoming frame.
    always_comb begin
        w_hs       = r_valid & bus.dout_ready;
        w_release  = (r_state == STREAM) & w_hs & r_last;
        w_full_rel = r_full;
        if (w_release) w_full_rel[r_rd_ptr] = 1'b0;
        w_drop     = bus.din_en & (&w_full_rel);
        w_accept   = bus.din_en & ~w_full_rel[r_wr_ptr];
        w_full_nxt = w_full_rel;
        w_we       = 2'b00;
        if (w_accept) begin
            w_full_nxt[r_wr_ptr] = 1'b1;
            w_we[r_wr_ptr]       = 1'b1;
        end

        w_load    = 1'b0;
        w_ld_bank = r_rd_ptr;
        w_ld_beat = '0;
        case (r_state)
            IDLE: begin
                if (r_full[r_rd_ptr]) w_load = 1'b1;
            end
            STREAM: begin
                if (w_hs && !r_last) begin
                    w_load    = 1'b1;
                    w_ld_beat = r_beat + BEAT_W'(1);
                end else if (w_hs && r_full[~r_rd_ptr]) begin
                    w_load    = 1'b1;
                    w_ld_bank = ~r_rd_ptr;
                end
            end
            default: ;
        endcase

        for (int l = 0; l < int'(LANES); l++) begin
            w_ld_re[l] = w_ld_bank ? w_re1[l] : w_re0[l];
            w_ld_im[l] = w_ld_bank ? w_im1[l] : w_im0[l];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_full     <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_dout_re  <= '{default: '0};
            r_dout_im  <= '{default: '0};
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_overflow <= w_drop;
            if (w_accept)  r_wr_ptr <= ~r_wr_ptr;
            if (w_release) r_rd_ptr <= ~r_rd_ptr;
            if (w_load) begin
                r_state   <= STREAM;
                r_valid   <= 1'b1;
                r_beat    <= w_ld_beat;
                r_last    <= (w_ld_beat == BEAT_W'(BEATS - 1));
                r_dout_re <= w_ld_re;
                r_dout_im <= w_ld_im;
            end else if (w_release) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign bus.dout_re    = r_dout_re;
    assign bus.dout_im    = r_dout_im;
    assign bus.dout_valid = r_valid;
    assign bus.dout_beat  = r_beat;
    assign bus.dout_last  = r_last;
    assign bus.overflow   = r_overflow;

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sits directly after the 512-point fixed-point FFT core.
- On the core's frame strobe, captures a full 512-bin result (re/im, bit-reversed order) into a ping-pong buffer.
- Replays each frame as 32 beats of 16 bins, in natural bin order, over a valid/ready stream.
- The consumer is the downstream demapper / readback logic. This block is the reader side of the core's parallel frame-output interface.

Parameters:
- WIDTH, 13, bit width of each signed re/im bin (<9.4> format, passed through unchanged).
- N, 512, bins per frame (power of two, log2 = 9).
- LANES, 16, bins per output beat. N/LANES = 32 beats per frame.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- din_re  in  signed WIDTH x [0:N-1]  frame real parts; index = bit-reversed bin number
- din_im  in  signed WIDTH x [0:N-1]  frame imaginary parts, same indexing
- din_en  in  1  one-cycle frame strobe; din_re/din_im valid in this cycle
- dout_re  out  signed WIDTH x [0:LANES-1]  beat real parts, lane l = bin 16*beat+l
- dout_im  out  signed WIDTH x [0:LANES-1]  beat imaginary parts
- dout_valid  out  1  beat valid
- dout_ready  in  1  consumer accepts beat when valid && ready
- dout_beat  out  5  beat index 0..31 of current beat
- dout_last  out  1  high with beat 31
- overflow  out  1  one-cycle pulse: frame dropped, both banks full

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: all outputs 0; bank full flags 0; wr_ptr=0, rd_ptr=0; beat counter 0; FSM in IDLE.
- Storage: two banks, each N x 2 x WIDTH registers, with full[1:0] flags.
- Write:
  - On din_en at edge E, the whole frame is copied into bank wr_ptr, full[wr_ptr] is set, and wr_ptr toggles.
  - If both banks are full at E (after same-edge release, see below), the frame is discarded, overflow pulses high for 1 cycle, and wr_ptr is unchanged.
- Reorder: output lane l of beat b reads stored index bitrev9(16*b+l). Data values are not modified; no arithmetic, saturation or rounding.
- FSM states:
  - IDLE: if full[rd_ptr], load beat 0 into the output registers, assert dout_valid, go to STREAM.
  - STREAM:
    - On handshake with beat<31: load beat+1 and keep dout_valid=1.
    - On handshake with beat 31 (dout_last): clear full[rd_ptr] and toggle rd_ptr.
      - If the other bank is full, load its beat 0 in the same edge, with no bubble, and stay in STREAM.
      - Otherwise drop dout_valid and go to IDLE.
  - No handshake: all dout_* held stable (standard stream rule; valid is never withdrawn without a handshake).
- Latency: din_en at edge E0 with bank empty and FSM IDLE → dout_valid=1 with beat 0 after edge E0+1. With dout_ready held at 1, a frame drains in 32 consecutive cycles.
- Simultaneous events:
  - Last-beat release and din_en on the same edge: the released bank counts as free, so the frame is accepted and there is no overflow.
  - din_en while streaming from the other bank: accepted, and never disturbs the bank being read.
- dout_beat and dout_last are registered together with the data.
- Reset mid-frame: streaming aborts immediately, both banks are invalidated, and there is no partial output after release.

Decomposition:
- Package fft_reorder_pkg:
  - constants N, LANES, BEATS=32, LOG2N=9
  - function bitrev9
  - typedef for the frame array and the beat array
  - FSM state enum {IDLE, STREAM}
- One sub-module, fft_reorder_bank: one storage bank with a capture enable and a 16-lane beat read port (bit-reverse address mapping inside). Instantiated twice.
- The top level holds the pointers, full flags, FSM and output registers.

Test Plan:
- Reset then single frame, with din_re[i]=i and din_im[i]=-i, dout_ready=1 → 32 consecutive beats. Beat 0 lanes = bitrev9(0..15) = 0,256,128,384,…; beat 31 lane 15 = 511; dout_last only on beat 31; dout_valid low afterwards.
- Backpressure: toggle dout_ready pseudo-randomly → every beat delivered exactly once, in order, with data stable while valid && !ready.
- Back-to-back frames A then B, B's din_en 5 cycles after A's → A beats 0–31 immediately followed by B beat 0 with no idle cycle; no overflow.
- Three frames with dout_ready=0 → third din_en produces overflow=1 for exactly 1 cycle. After releasing ready, only frames 1 and 2 are output.
- Both banks full, and din_en lands on the same edge as the last-beat handshake → new frame accepted, no overflow, streamed after the pending bank.
- Assert rstn=0 at beat 10 → outputs 0 at once. After release, with no new din_en, dout_valid stays 0 for 50 cycles.
